note_sequencer: RTL
===================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high: i_clk  in  1  rising-edge clock; i_rst  in  1  async active-high reset.
REQ-002 SHALL have ports: i_tick  in  1  one-cycle frame-tick pulse.
REQ-003 SHALL have ports: i_start  in  1  start-song pulse; i_stop  in  1  abort pulse.
REQ-004 SHALL have ports: o_song_addr  out  8  song ROM word address (registered); i_song_data  in  16  ROM word, valid one cycle after o_song_addr changes.
REQ-005 SHALL have ports: o_load  out  1  one-cycle load pulse to the shared note player; o_voice  out  2  voice index qualifying o_load.
REQ-006 SHALL have ports: o_pitch  out  6; o_duration  out  5; o_instrument  out  4; all held stable from o_load until i_done.
REQ-007 SHALL have ports: i_done  in  1  note-player completion pulse.
REQ-008 SHALL have ports: o_active  out  4  per-voice playing mask; o_busy  out  1  not IDLE; o_overrun  out  1  sticky tick-overrun flag.

Function
REQ-009 SHALL support 4 voices sharing one song ROM and one note player; ROM words 0..3 hold voice 0..3 track start addresses in bits [7:0].
REQ-010 SHALL decode note words as [15]=0, [14:10] duration, [9:4] pitch, [3:0] instrument.
REQ-011 SHALL decode end-of-track words as [15]=1, [14] loop, [7:0] loop address.
REQ-012 SHALL implement states IDLE, INIT_ADDR, INIT_DATA, WAIT_TICK, SCAN, FETCH_ADDR, FETCH_DATA, LOAD, WAIT_DONE.
REQ-013 In IDLE, SHALL go to INIT_ADDR on i_start. INIT_ADDR/INIT_DATA SHALL read words 0..3 in order (one address per cycle, data captured the next cycle) into per-voice pointers, set o_active=4'hF and per-voice counters to 0, then go to WAIT_TICK.
REQ-014 In WAIT_TICK, on i_tick or tick-pending, SHALL clear pending, set voice index to 0 and go to SCAN.
REQ-015 In SCAN, for an active voice with counter 0, SHALL go to FETCH_ADDR.
REQ-016 In SCAN, for an active voice with counter nonzero, SHALL decrement its counter and advance. SCAN SHALL skip inactive voices.
REQ-017 After voice 3 is serviced, SHALL return to WAIT_TICK.
REQ-018 FETCH_ADDR SHALL drive o_song_addr = pointer[v]; FETCH_DATA SHALL decode i_song_data.
REQ-019 For a note word, SHALL latch the fields and set counter[v] = duration, so the note lasts duration+1 ticks. SHALL set pointer[v] = pointer[v]+1 mod 256 (wraps 255->0) and go to LOAD.
REQ-020 For end-of-track with loop=1, SHALL set pointer[v] = loop address and re-enter FETCH_ADDR once.
REQ-021 A second consecutive end-of-track word for the same voice in the same scan, or loop=0, SHALL clear o_active[v] and advance.
REQ-022 LOAD SHALL assert o_load for exactly one cycle with o_voice=v, then go to WAIT_DONE. WAIT_DONE SHALL advance on i_done. i_done outside WAIT_DONE SHALL be ignored.
REQ-023 When o_active reaches 0, SHALL return to IDLE after finishing the current scan.
REQ-024 i_tick outside IDLE and WAIT_TICK SHALL set tick-pending. i_tick while pending is already set SHALL set o_overrun; o_overrun is cleared only by reset or i_start.
REQ-025 i_stop in any state SHALL force IDLE next cycle, clear o_active and pending, and suppress o_load. Simultaneous i_start and i_stop: stop wins. i_start outside IDLE SHALL be ignored.
REQ-026 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 On i_rst SHALL immediately enter IDLE with all outputs 0: o_song_addr=0, o_load=0, o_voice=0, o_pitch=0, o_duration=0, o_instrument=0, o_active=0, o_busy=0, o_overrun=0.
REQ-028 On i_rst SHALL zero all pointers, counters and pending. Reset mid-fetch or mid-WAIT_DONE SHALL abandon the operation without any o_load.

Structure
REQ-029 SHALL place the state encoding, word field positions, end-of-track bit positions, NUM_VOICES=4 and the track table base (0) in shared package note_seq_pkg.
REQ-030 SHALL instantiate one sub-module, voice_duration_counter (5-bit counter with load, decrement and zero flag), once per voice.

Verification
REQ-031 Start with table {10,20,30,40} and word 10 = note d=2,p=5,i=3 -> first tick gives o_load with o_voice=0, pitch 5, instr 3; voice 0 next reloads on tick 4.
REQ-032 Voice 1 track [EOT loop=1 addr 20] -> voice 1 stays active, refetches 20, and o_active[1] drops on the second EOT in the same scan.
REQ-033 Word with loop=0 on all voices -> o_active=0, then IDLE, o_busy=0 after that scan.
REQ-034 Hold i_done low, pulse i_tick twice -> o_overrun=1 and stays 1 until i_start.
REQ-035 Pulse i_stop during WAIT_DONE, or assert i_rst during FETCH_DATA -> IDLE next cycle (immediately for reset), no further o_load, o_active=0.
REQ-036 Pointer at 255 reading a note word -> next fetch address 0.

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared definitions for the four-voice note sequencer: state encoding,
// song-word field positions and track-table layout.
package note_seq_pkg;

  localparam int NUM_VOICES = 4;
  localparam logic [1:0] LAST_VOICE = 2'(NUM_VOICES - 1);
  localparam logic [7:0] TRACK_BASE = 8'd0;

  // Note word: [15]=0, [14:10] duration, [9:4] pitch, [3:0] instrument
  localparam int DUR_MSB   = 14;
  localparam int DUR_LSB   = 10;
  localparam int PITCH_MSB = 9;
  localparam int PITCH_LSB = 4;
  localparam int INSTR_MSB = 3;
  localparam int INSTR_LSB = 0;

  // End-of-track word: [15]=1, [14] loop, [7:0] loop address
  localparam int EOT_BIT       = 15;
  localparam int LOOP_BIT      = 14;
  localparam int LOOP_ADDR_MSB = 7;
  localparam int LOOP_ADDR_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_ADDR,
    ST_INIT_DATA,
    ST_WAIT_TICK,
    ST_SCAN,
    ST_FETCH_ADDR,
    ST_FETCH_DATA,
    ST_LOAD,
    ST_WAIT_DONE
  } seq_state_t;

endpackage

// File: rtl/voice_duration_counter.sv
// Per-voice tick countdown: loads a note duration, decrements once per scan,
// and flags zero when the voice needs its next word.
module voice_duration_counter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [4:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [4:0] count_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= 5'd0;
    end else if (i_load) begin
      count_q <= i_load_val;
    end else if (i_dec && (count_q != 5'd0)) begin
      count_q <= count_q - 5'd1;
    end
  end

  assign o_zero = (count_q == 5'd0);

endmodule

// File: rtl/note_sequencer.sv
// Four-voice song sequencer: walks per-voice tracks in a shared song ROM on
// each frame tick and hands notes one at a time to a shared note player.
module note_sequencer
  import note_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic        i_stop,
  output logic [7:0]  o_song_addr,
  input  logic [15:0] i_song_data,
  output logic        o_load,
  output logic [1:0]  o_voice,
  output logic [5:0]  o_pitch,
  output logic [4:0]  o_duration,
  output logic [3:0]  o_instrument,
  input  logic        i_done,
  output logic [3:0]  o_active,
  output logic        o_busy,
  output logic        o_overrun,
  output seq_state_t  o_dbg_state
);

  // Player handshake: o_load is a one-cycle request qualified by o_voice; the
  // note fields hold until i_done, which is honoured only in ST_WAIT_DONE.

  seq_state_t state_q, state_nxt;

  logic [1:0] voice_q;
  logic [7:0] ptr_q [NUM_VOICES];
  logic [3:0] active_q;
  logic       pending_q;
  logic       looped_q;
  logic       overrun_q;

  logic [NUM_VOICES-1:0] cnt_load, cnt_dec, cnt_zero;
  logic [4:0]            cnt_val;
  logic                  advance, kill;
  logic [3:0]            active_after;

  logic       is_eot, is_loop;
  logic [7:0] loop_addr;
  logic [1:0] voice_inc;

  assign is_eot    = i_song_data[EOT_BIT];
  assign is_loop   = i_song_data[LOOP_BIT];
  assign loop_addr = i_song_data[LOOP_ADDR_MSB:LOOP_ADDR_LSB];
  assign voice_inc = voice_q + 2'd1;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_cnt
    voice_duration_counter u_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (cnt_load[g]),
      .i_load_val (cnt_val),
      .i_dec      (cnt_dec[g]),
      .o_zero     (cnt_zero[g])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt    = state_q;
    advance      = 1'b0;
    kill         = 1'b0;
    cnt_load     = '0;
    cnt_dec      = '0;
    cnt_val      = 5'd0;
    active_after = active_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          cnt_load  = '1;
          state_nxt = ST_INIT_ADDR;
        end
      end
      ST_INIT_ADDR: state_nxt = ST_INIT_DATA;
      ST_INIT_DATA: state_nxt = (voice_q == LAST_VOICE) ? ST_WAIT_TICK : ST_INIT_ADDR;
      ST_WAIT_TICK: if (i_tick || pending_q) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (!active_q[voice_q]) begin
          advance = 1'b1;
        end else if (cnt_zero[voice_q]) begin
          state_nxt = ST_FETCH_ADDR;
        end else begin
          cnt_dec[voice_q] = 1'b1;
          advance          = 1'b1;
        end
      end
      ST_FETCH_ADDR: state_nxt = ST_FETCH_DATA;
      ST_FETCH_DATA: begin
        if (!is_eot) begin
          cnt_val           = i_song_data[DUR_MSB:DUR_LSB];
          cnt_load[voice_q] = 1'b1;
          state_nxt         = ST_LOAD;
        end else if (is_loop && !looped_q) begin
          state_nxt = ST_FETCH_ADDR;
        end else begin
          kill    = 1'b1;
          advance = 1'b1;
        end
      end
      ST_LOAD:      state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (i_done) advance = 1'b1;
      default:      state_nxt = ST_IDLE;
    endcase
    if (kill) active_after[voice_q] = 1'b0;
    // The scan always finishes all voices before deciding to go idle.
    if (advance) begin
      if (voice_q != LAST_VOICE)  state_nxt = ST_SCAN;
      else if (active_after == '0) state_nxt = ST_IDLE;
      else                         state_nxt = ST_WAIT_TICK;
    end
    if (i_stop) state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      voice_q      <= 2'd0;
      o_song_addr  <= 8'd0;
      o_pitch      <= 6'd0;
      o_duration   <= 5'd0;
      o_instrument <= 4'd0;
      active_q     <= 4'd0;
      pending_q    <= 1'b0;
      looped_q     <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) ptr_q[i] <= 8'd0;
    end else begin
      if (i_tick && (state_q != ST_IDLE) && (state_q != ST_WAIT_TICK)) begin
        pending_q <= 1'b1;
        if (pending_q) overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            voice_q     <= 2'd0;
            o_song_addr <= TRACK_BASE;
            overrun_q   <= 1'b0;
          end
        end
        ST_INIT_DATA: begin
          ptr_q[voice_q] <= i_song_data[7:0];
          if (voice_q != LAST_VOICE) begin
            voice_q     <= voice_inc;
            o_song_addr <= TRACK_BASE + {6'd0, voice_inc};
          end else begin
            active_q <= 4'hF;
          end
        end
        ST_WAIT_TICK: begin
          if (i_tick || pending_q) begin
            pending_q <= 1'b0;
            voice_q   <= 2'd0;
            looped_q  <= 1'b0;
          end
        end
        ST_SCAN: if (state_nxt == ST_FETCH_ADDR) o_song_addr <= ptr_q[voice_q];
        ST_FETCH_DATA: begin
          if (!is_eot) begin
            o_pitch        <= i_song_data[PITCH_MSB:PITCH_LSB];
            o_duration     <= i_song_data[DUR_MSB:DUR_LSB];
            o_instrument   <= i_song_data[INSTR_MSB:INSTR_LSB];
            ptr_q[voice_q] <= ptr_q[voice_q] + 8'd1;
          end else if (is_loop && !looped_q) begin
            ptr_q[voice_q] <= loop_addr;
            o_song_addr    <= loop_addr;
            looped_q       <= 1'b1;
          end else begin
            active_q <= active_after;
          end
        end
        default: ;
      endcase
      if (advance) begin
        looped_q <= 1'b0;
        if (voice_q != LAST_VOICE) voice_q <= voice_inc;
      end
      if (i_stop) begin
        active_q  <= 4'd0;
        pending_q <= 1'b0;
      end
    end
  end

  assign o_load      = (state_q == ST_LOAD);
  assign o_voice     = voice_q;
  assign o_active    = active_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_overrun   = overrun_q;
  assign o_dbg_state = state_q;

endmodule
